corral_host: RTL and testbench
==============================

CORRAL_HOST -- requirements
Module: corral_host

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the saturating move counter.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  host requests one game move.
REQ-005 cmd_move  input  3  move code forwarded to the game.
REQ-006 cmd_ready  output  1  high only in IDLE; a move is accepted on cmd_valid && cmd_ready.
REQ-007 clear  input  1  starts a new game: leaves DONE, zeroes move_count.
REQ-008 game_enter  output  1  drives the game's enter pin.
REQ-009 game_move  output  3  drives the game's move pin.
REQ-010 game_data  input  4  game data pin (cowboy, then horse position).
REQ-011 game_gameover, game_lostwon, game_ready  input  1 each  game status pins.
REQ-012 rsp_valid  output  1  captured result available.
REQ-013 rsp_ready  input  1  host consumes the result on rsp_valid && rsp_ready.
REQ-014 rsp_cowboy, rsp_horse  output  4 each  captured positions.
REQ-015 rsp_gameover, rsp_lostwon, rsp_gready  output  1 each  captured status bits.
REQ-016 move_count  output  CNT_W  number of moves accepted since the last clear.

Function
REQ-017 SHALL implement states IDLE, ISSUE, CAP_COW, CAP_HORSE, CAP_STAT, RESP and DONE.
REQ-018 IDLE: on accept, SHALL register cmd_move, increment move_count, and go to ISSUE.
REQ-019 ISSUE (one cycle): SHALL drive game_enter=1 and game_move=registered move, then go to CAP_COW.
REQ-020 game_enter SHALL be 0 and game_move SHALL be 0 in every state except ISSUE.
REQ-021 CAP_COW: SHALL sample game_data into rsp_cowboy at the closing edge, then go to CAP_HORSE.
REQ-022 CAP_HORSE: SHALL sample game_data into rsp_horse, then go to CAP_STAT.
REQ-023 CAP_STAT: SHALL sample game_gameover, game_lostwon and game_ready, then go to RESP.
REQ-024 Latency: rsp_valid SHALL rise exactly 4 clock edges after the accept edge.
REQ-025 RESP: SHALL hold rsp_valid=1 and all rsp_* values stable until rsp_ready; backpressure of unbounded length is legal.
REQ-026 On the RESP handshake: SHALL go to DONE if rsp_gameover=1, else to IDLE.
REQ-027 DONE: cmd_ready SHALL be 0; clear SHALL move to IDLE and zero move_count.
REQ-028 clear in IDLE SHALL zero move_count.
REQ-029 clear in IDLE and cmd_valid in the same cycle: clear wins; the command is not accepted that cycle.
REQ-030 clear in ISSUE, CAP_*, or RESP SHALL be ignored.
REQ-031 move_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 rsp_* values SHALL persist after the handshake until overwritten by the next capture.

Reset
REQ-033 reset_n low SHALL asynchronously force IDLE and zero all outputs and registers, including move_count; it aborts any capture in progress.
REQ-034 After reset_n deasserts, cmd_ready SHALL be 1 on the first cycle.

Structure
REQ-035 Package corral_pkg SHALL hold the state enum, MOVE_W=3 and POS_W=4.
REQ-036 Sub-module corral_sat_counter (parameterised width; inc and clr inputs) SHALL implement move_count; all other logic is flat.

Verification
REQ-037 Bench with a behavioural game model: move=3'b101, game reports cowboy 4'h6, horse 4'h9, gameover=0 -> rsp_valid 4 edges after accept, rsp_cowboy=6, rsp_horse=9, return to IDLE, move_count=1.
REQ-038 rsp_ready held low for 10 cycles -> rsp_* stable and cmd_ready=0 throughout; handshake on cycle 11 -> IDLE.
REQ-039 Game reports gameover=1, lostwon=1 -> DONE, cmd_valid ignored; clear -> IDLE with move_count=0.
REQ-040 CNT_W=2 and 5 moves -> move_count=3 with no wrap.
REQ-041 reset_n pulsed low during CAP_HORSE -> immediate IDLE, game_enter=0, rsp_valid=0, move_count=0.
REQ-042 clear and cmd_valid asserted together in IDLE -> no game_enter pulse and move_count=0.

Source files
------------

// File: rtl/corral_pkg.sv
// Shared types and widths for the corral game host adapter.
package corral_pkg;
    localparam int MOVE_W = 3;
    localparam int POS_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAP_COW,
        S_CAP_HORSE,
        S_CAP_STAT,
        S_RESP,
        S_DONE
    } state_e;
endpackage

// File: rtl/corral_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module corral_sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                      count_q <= '0;
        else if (clr)                      count_q <= '0;
        else if (inc && (count_q != '1))   count_q <= count_q + 1'b1;
    end

    assign count = count_q;
endmodule

// File: rtl/corral_host.sv
// Host-side adapter for the corral game: issues one move per command, then
// captures cowboy, horse and status over three cycles and holds them for the host.
module corral_host
    import corral_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    input  logic [MOVE_W-1:0] cmd_move,
    output logic              cmd_ready,
    input  logic              clear,
    output logic              game_enter,
    output logic [MOVE_W-1:0] game_move,
    input  logic [POS_W-1:0]  game_data,
    input  logic              game_gameover,
    input  logic              game_lostwon,
    input  logic              game_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [POS_W-1:0]  rsp_cowboy,
    output logic [POS_W-1:0]  rsp_horse,
    output logic              rsp_gameover,
    output logic              rsp_lostwon,
    output logic              rsp_gready,
    output logic [CNT_W-1:0]  move_count
);
    state_e              state_q;
    logic                game_enter_q;
    logic [MOVE_W-1:0]   game_move_q;
    logic                rsp_valid_q;
    logic [POS_W-1:0]    rsp_cowboy_q, rsp_horse_q;
    logic                rsp_gameover_q, rsp_lostwon_q, rsp_gready_q;
    logic                accept, cnt_clr;

    // clear beats a simultaneous command in IDLE
    assign accept  = (state_q == S_IDLE) && cmd_valid && !clear;
    assign cnt_clr = clear && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            game_enter_q   <= 1'b0;
            game_move_q    <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_cowboy_q   <= '0;
            rsp_horse_q    <= '0;
            rsp_gameover_q <= 1'b0;
            rsp_lostwon_q  <= 1'b0;
            rsp_gready_q   <= 1'b0;
        end else begin
            // enter/move are a single-cycle pulse, only while in ISSUE
            game_enter_q <= 1'b0;
            game_move_q  <= '0;
            case (state_q)
                S_IDLE: if (accept) begin
                    game_enter_q <= 1'b1;
                    game_move_q  <= cmd_move;
                    state_q      <= S_ISSUE;
                end
                S_ISSUE:     state_q <= S_CAP_COW;
                S_CAP_COW: begin
                    rsp_cowboy_q <= game_data;
                    state_q      <= S_CAP_HORSE;
                end
                S_CAP_HORSE: begin
                    rsp_horse_q <= game_data;
                    state_q     <= S_CAP_STAT;
                end
                S_CAP_STAT: begin
                    rsp_gameover_q <= game_gameover;
                    rsp_lostwon_q  <= game_lostwon;
                    rsp_gready_q   <= game_ready;
                    rsp_valid_q    <= 1'b1;
                    state_q        <= S_RESP;
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= rsp_gameover_q ? S_DONE : S_IDLE;
                end
                S_DONE:  if (clear) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    corral_sat_counter #(.W(CNT_W)) u_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (accept),
        .clr     (cnt_clr),
        .count   (move_count)
    );

    // gated by reset so every output reads zero while reset is held
    assign cmd_ready    = reset_n && (state_q == S_IDLE);
    assign game_enter   = game_enter_q;
    assign game_move    = game_move_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_cowboy   = rsp_cowboy_q;
    assign rsp_horse    = rsp_horse_q;
    assign rsp_gameover = rsp_gameover_q;
    assign rsp_lostwon  = rsp_lostwon_q;
    assign rsp_gready   = rsp_gready_q;
endmodule

// File: tb/tb_corral_host.sv
// Directed bench for corral_host with a behavioural game model; second instance
// at CNT_W=2 shares stimulus to exercise counter saturation.
module tb_corral_host;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       cmd_valid, clear, rsp_ready;
    logic [2:0] cmd_move;
    logic [3:0] game_data;
    logic       game_gameover, game_lostwon, game_ready;

    logic       cmd_ready, game_enter, rsp_valid, rsp_gameover, rsp_lostwon, rsp_gready;
    logic [2:0] game_move;
    logic [3:0] rsp_cowboy, rsp_horse;
    logic [7:0] move_count;

    logic       cmd_ready2, game_enter2, rsp_valid2, rsp_gameover2, rsp_lostwon2, rsp_gready2;
    logic [2:0] game_move2;
    logic [3:0] rsp_cowboy2, rsp_horse2;
    logic [1:0] move_count2;

    logic [3:0] m_cow, m_horse;
    logic       m_ph;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    corral_host #(.CNT_W(8)) u_dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_move(cmd_move),
        .cmd_ready(cmd_ready), .clear(clear), .game_enter(game_enter), .game_move(game_move),
        .game_data(game_data), .game_gameover(game_gameover), .game_lostwon(game_lostwon),
        .game_ready(game_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_cowboy(rsp_cowboy), .rsp_horse(rsp_horse), .rsp_gameover(rsp_gameover),
        .rsp_lostwon(rsp_lostwon), .rsp_gready(rsp_gready), .move_count(move_count)
    );

    corral_host #(.CNT_W(2)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_move(cmd_move),
        .cmd_ready(cmd_ready2), .clear(clear), .game_enter(game_enter2), .game_move(game_move2),
        .game_data(game_data), .game_gameover(game_gameover), .game_lostwon(game_lostwon),
        .game_ready(game_ready), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_cowboy(rsp_cowboy2), .rsp_horse(rsp_horse2), .rsp_gameover(rsp_gameover2),
        .rsp_lostwon(rsp_lostwon2), .rsp_gready(rsp_gready2), .move_count(move_count2)
    );

    // Game model: cowboy on the cycle after enter, horse on the one after that.
    always @(posedge clock) begin
        if (game_enter) begin
            game_data <= m_cow;
            m_ph      <= 1'b1;
        end else if (m_ph) begin
            game_data <= m_horse;
            m_ph      <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns after the handshake negedge.
    task automatic do_move(input logic [2:0] mv, input int hold, input logic clr_in_resp,
                           input int exp_cnt, input string tag);
        int n;
        cmd_valid = 1'b1;
        cmd_move  = mv;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_move  = 3'd0;
        chk({tag, "_enter"}, {31'd0, game_enter}, 32'd1);
        chk({tag, "_move"}, {29'd0, game_move}, {29'd0, mv});
        chk({tag, "_cnt"}, {24'd0, move_count}, exp_cnt);
        @(negedge clock);
        chk({tag, "_enter_off"}, {31'd0, game_enter}, 32'd0);
        chk({tag, "_move_off"}, {29'd0, game_move}, 32'd0);
        n = 2;
        while (!rsp_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_latency"}, n - 1, 32'd4);
        chk({tag, "_cow"}, {28'd0, rsp_cowboy}, {28'd0, m_cow});
        chk({tag, "_horse"}, {28'd0, rsp_horse}, {28'd0, m_horse});
        clear = clr_in_resp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk({tag, "_bp_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, "_bp_ready"}, {31'd0, cmd_ready}, 32'd0);
            chk({tag, "_bp_cow"}, {28'd0, rsp_cowboy}, {28'd0, m_cow});
            chk({tag, "_bp_horse"}, {28'd0, rsp_horse}, {28'd0, m_horse});
            chk({tag, "_bp_cnt"}, {24'd0, move_count}, exp_cnt);
        end
        clear     = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_move = 3'd0; clear = 1'b0; rsp_ready = 1'b0;
        game_gameover = 1'b0; game_lostwon = 1'b0; game_ready = 1'b0;
        m_cow = 4'h0; m_horse = 4'h0;
        repeat (2) @(negedge clock);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_enter", {31'd0, game_enter}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_cnt", {24'd0, move_count}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // basic move with 10 cycles of backpressure
        m_cow = 4'h6; m_horse = 4'h9; game_gameover = 1'b0; game_lostwon = 1'b0; game_ready = 1'b1;
        do_move(3'b101, 10, 1'b0, 1, "t1");
        chk("t1_idle", {31'd0, cmd_ready}, 32'd1);
        chk("t1_cnt", {24'd0, move_count}, 32'd1);
        chk("t1_persist_cow", {28'd0, rsp_cowboy}, 32'h6);
        chk("t1_persist_horse", {28'd0, rsp_horse}, 32'h9);
        chk("t1_gready", {31'd0, rsp_gready}, 32'd1);
        chk("t1_gameover", {31'd0, rsp_gameover}, 32'd0);

        // game over -> DONE; clear during RESP ignored
        m_cow = 4'h2; m_horse = 4'hf; game_gameover = 1'b1; game_lostwon = 1'b1; game_ready = 1'b0;
        do_move(3'b010, 3, 1'b1, 2, "t2");
        chk("t2_done_ready", {31'd0, cmd_ready}, 32'd0);
        chk("t2_gameover", {31'd0, rsp_gameover}, 32'd1);
        chk("t2_lostwon", {31'd0, rsp_lostwon}, 32'd1);
        chk("t2_gready", {31'd0, rsp_gready}, 32'd0);
        cmd_valid = 1'b1; cmd_move = 3'd7;
        repeat (2) begin
            @(negedge clock);
            chk("t2_done_noenter", {31'd0, game_enter}, 32'd0);
            chk("t2_done_cnt", {24'd0, move_count}, 32'd2);
        end
        cmd_valid = 1'b0;
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("t2_clear_idle", {31'd0, cmd_ready}, 32'd1);
        chk("t2_clear_cnt", {24'd0, move_count}, 32'd0);
        chk("t2_persist_cow", {28'd0, rsp_cowboy}, 32'h2);

        // clear and cmd_valid together in IDLE
        game_gameover = 1'b0; game_lostwon = 1'b0;
        do_move(3'b001, 0, 1'b0, 1, "t3");
        clear = 1'b1; cmd_valid = 1'b1; cmd_move = 3'd4;
        @(negedge clock);
        clear = 1'b0; cmd_valid = 1'b0;
        chk("t3_noenter", {31'd0, game_enter}, 32'd0);
        chk("t3_cnt", {24'd0, move_count}, 32'd0);
        chk("t3_ready", {31'd0, cmd_ready}, 32'd1);
        @(negedge clock);
        chk("t3_noenter2", {31'd0, game_enter}, 32'd0);

        // reset in the middle of a capture (CAP_HORSE)
        m_cow = 4'ha; m_horse = 4'h5;
        cmd_valid = 1'b1; cmd_move = 3'd3;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        chk("t4_enter", {31'd0, game_enter}, 32'd0);
        chk("t4_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t4_cnt", {24'd0, move_count}, 32'd0);
        chk("t4_cow", {28'd0, rsp_cowboy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("t4_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (5) @(negedge clock);
        chk("t4_still_valid0", {31'd0, rsp_valid}, 32'd0);
        chk("t4_still_enter0", {31'd0, game_enter}, 32'd0);

        // saturation: CNT_W=2 stops at 3 after five moves
        m_cow = 4'h1; m_horse = 4'h2;
        for (int i = 0; i < 5; i++) begin
            do_move(3'(i), 0, 1'b0, i + 1, "t5");
            chk("t5_cnt2", {30'd0, move_count2}, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
        end
        chk("t5_cnt8", {24'd0, move_count}, 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
